apb_regfile_slave: RTL and testbench
====================================

Name: apb_regfile_slave

Overview:
- APB responder (completer) holding a small 8-bit register file.
- Inserts a parameterised number of wait states on every transfer.
- Signals PSLVERR on illegal accesses.
- Sits on the bus opposite the APB bridge and serves as the configurable-latency, error-capable end point for master verification.

Parameters:
- NUM_REGS, 16: number of 8-bit registers, addresses 0..NUM_REGS-1 (2..256).
- WAIT_CYCLES, 2: PREADY-low access-phase cycles before completion (0..15).
- ID_VALUE, 8'hA5: constant returned by read-only register 0.

Ports:
- PCLK  input  1  bus clock, all state on rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- PSEL  input  1  slave select.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  8  register address.
- PWDATA  input  8  write data.
- PRDATA  output  8  read data, valid only while PREADY=1 on a read.
- PREADY  output  1  transfer completion.
- PSLVERR  output  1  error response, valid only while PREADY=1.

Behaviour:
- Clock and reset: one clock, PCLK; reset PRESETn is asynchronous and active-low.
- Reset values:
  - FSM in IDLE, wait counter 0.
  - PREADY=0, PSLVERR=0, PRDATA=8'h00.
  - All writable registers 8'h00.
  - Reset asserted mid-transfer aborts it immediately; no write commits.
- FSM states: IDLE, ACCESS.
- IDLE:
  - PREADY=0.
  - On an edge with PSEL=1 and PENABLE=0 (setup phase), latch PADDR and PWRITE, load cnt<=WAIT_CYCLES, go to ACCESS.
  - On the same edge, compute the error flag: err = (PADDR >= NUM_REGS) | (PWRITE & PADDR==0).
  - For reads, also capture rdata (reg[PADDR], or ID_VALUE for addr 0, or 8'h00 when err).
- ACCESS:
  - PREADY = (cnt==0). This is a Moore output from registered state only; there is no combinational path from bus inputs.
  - While cnt!=0 and PSEL&PENABLE: cnt decrements each edge.
  - Completion edge: PSEL&PENABLE&PREADY. Commit the write if PWRITE & !err (reg[addr]<=PWDATA as sampled that edge), then go to IDLE.
  - PSEL falling in ACCESS before completion aborts: go to IDLE, no write, no error.
  - PENABLE low while PSEL high in ACCESS is a protocol violation. Treat it as a new setup: reload cnt, re-latch address, stay in ACCESS.
- Latency: a transfer occupies 1 setup + WAIT_CYCLES + 1 cycles. Back-to-back transfers need the master's next setup cycle; the slave is in IDLE by then.
- Outputs outside ACCESS&PREADY:
  - PSLVERR=0.
  - PRDATA=8'h00 (PRDATA also 8'h00 on writes).
- On err:
  - Reads return 8'h00.
  - Writes are discarded; register contents unchanged.
  - PSLVERR=1 only in the completion cycle.
- Address decode compares the full 8-bit PADDR; there is no aliasing and no wrap.
- Data read in the same transfer sequence reflects writes completed in earlier transfers (registers update on the completion edge; the read value is captured at the setup edge).

Test Plan:
- Reset then read addr 0 -> PREADY high on 3rd cycle after setup (WAIT_CYCLES=2), PRDATA=8'hA5, PSLVERR=0; read addr 5 -> PRDATA=8'h00.
- Write 8'h3C to addr 5, then read addr 5 -> write completes after exactly 2 PREADY-low cycles; read returns 8'h3C, PSLVERR=0 both transfers.
- Write 8'hFF to addr 0 and write to addr 8'h20 (NUM_REGS=16) -> PSLVERR=1 with PREADY on completion cycle; subsequent reads of addr 0 = 8'hA5, addr 15 unchanged.
- Read addr 8'h10 -> PSLVERR=1, PRDATA=8'h00; next read of addr 5 -> PSLVERR=0.
- Drop PSEL after 1 wait cycle of write 8'h77 to addr 3; separately, assert PRESETn=0 mid-write of 8'h55 to addr 4 -> addr 3 and addr 4 read 8'h00, PREADY/PSLVERR low immediately on reset.
- Re-run with WAIT_CYCLES=0 -> PREADY=1 in first access cycle; 10 back-to-back writes/reads to addrs 1..10 all return written data with no errors.

Source files
------------

// File: rtl/apb_regfile_slave.sv
// APB completer holding a small 8-bit register file with a fixed number of
// wait states per transfer and PSLVERR on illegal accesses.
//
// Ports:
//   PCLK     - bus clock, all state on rising edge
//   PRESETn  - asynchronous active-low reset
//   PSEL     - slave select
//   PENABLE  - access-phase indicator
//   PWRITE   - 1 = write, 0 = read
//   PADDR    - 8-bit register address (full decode, no aliasing)
//   PWDATA   - write data, sampled on the completion edge
//   PRDATA   - read data, non-zero only while PREADY=1 on a read
//   PREADY   - transfer completion (registered, no path from bus inputs)
//   PSLVERR  - error response, only while PREADY=1
//
// Register 0 is a read-only ID returning ID_VALUE; writes to it, and any
// access at or above NUM_REGS, complete with PSLVERR and have no effect.
module apb_regfile_slave #(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StAccess = 1'b1;

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);
  // 9 bits so NUM_REGS=256 still compares correctly against an 8-bit address.
  localparam logic [8:0] NumRegs9 = 9'(NUM_REGS);

  logic [0:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic       write_q, write_d;
  logic       err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  // Index 0 is the constant ID register, so no storage is kept for it.
  logic [7:0] regs_q [1:NUM_REGS-1];
  logic [7:0] regs_d [1:NUM_REGS-1];

  logic       setup_err;
  logic [7:0] setup_rdata;

  // Error flag and read data are resolved at the setup edge, so a read sees
  // the register contents as of the start of the transfer.
  always_comb begin
    setup_err   = ({1'b0, PADDR} >= NumRegs9) | (PWRITE & (PADDR == 8'h00));
    setup_rdata = 8'h00;
    if (!PWRITE && !setup_err) begin
      if (PADDR == 8'h00) begin
        setup_rdata = ID_VALUE;
      end else begin
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
          if (PADDR == 8'(i)) setup_rdata = regs_q[i];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    regs_d  = regs_q;

    case (state_q)
      StIdle: begin
        if (PSEL && !PENABLE) begin
          state_d = StAccess;
          cnt_d   = WaitInit;
          addr_d  = PADDR;
          write_d = PWRITE;
          err_d   = setup_err;
          rdata_d = setup_rdata;
        end
      end
      StAccess: begin
        if (!PSEL) begin
          // Master abandoned the transfer: no write, no error.
          state_d = StIdle;
        end else if (!PENABLE) begin
          // Protocol violation: treat as a fresh setup phase.
          cnt_d   = WaitInit;
          addr_d  = PADDR;
          write_d = PWRITE;
          err_d   = setup_err;
          rdata_d = setup_rdata;
        end else if (cnt_q == 4'd0) begin
          state_d = StIdle;
          if (write_q && !err_q) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
              if (addr_q == 8'(i)) regs_d[i] = PWDATA;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 8'h00;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
      for (int unsigned i = 1; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      regs_q  <= regs_d;
    end
  end

  always_comb begin
    PREADY  = (state_q == StAccess) && (cnt_q == 4'd0);
    PSLVERR = PREADY & err_q;
    PRDATA  = (PREADY && !write_q) ? rdata_q : 8'h00;
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
module tb_apb_regfile_slave;

  logic       clk;
  logic       rst_n;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic       use_w0;

  logic [7:0] prdata2, prdata0, prdata;
  logic       pready2, pready0, pready;
  logic       pslverr2, pslverr0, pslverr;

  // Two instances: WAIT_CYCLES=2 and WAIT_CYCLES=0, selected by use_w0.
  apb_regfile_slave #(.NUM_REGS(16), .WAIT_CYCLES(2), .ID_VALUE(8'hA5)) u_dut_w2 (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .PSEL    (psel & ~use_w0),
    .PENABLE (penable),
    .PWRITE  (pwrite),
    .PADDR   (paddr),
    .PWDATA  (pwdata),
    .PRDATA  (prdata2),
    .PREADY  (pready2),
    .PSLVERR (pslverr2)
  );

  apb_regfile_slave #(.NUM_REGS(16), .WAIT_CYCLES(0), .ID_VALUE(8'hA5)) u_dut_w0 (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .PSEL    (psel & use_w0),
    .PENABLE (penable),
    .PWRITE  (pwrite),
    .PADDR   (paddr),
    .PWDATA  (pwdata),
    .PRDATA  (prdata0),
    .PREADY  (pready0),
    .PSLVERR (pslverr0)
  );

  assign prdata  = use_w0 ? prdata0 : prdata2;
  assign pready  = use_w0 ? pready0 : pready2;
  assign pslverr = use_w0 ? pslverr0 : pslverr2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain memory image per instance.
  logic [7:0] mem [2][256];

  function automatic bit model_err(bit wr, logic [7:0] a);
    return (int'(a) >= 16) || (wr && a == 8'h00);
  endfunction

  function automatic logic [7:0] model_rd(bit w0, bit wr, logic [7:0] a);
    if (wr || model_err(wr, a)) return 8'h00;
    if (a == 8'h00) return 8'hA5;
    return mem[w0][a];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 256; j++) mem[k][j] = 8'h00;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the bus idle.
  task automatic do_xfer(input bit wr, input logic [7:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output bit er, output int waits);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    while (!pready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    rd = prdata;
    er = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic run_xfer(input string name, input bit w0, input bit wr, input logic [7:0] a,
                          input logic [7:0] d, input logic [7:0] exp_rd, input bit exp_err,
                          input int exp_waits);
    logic [7:0] rd;
    bit er;
    int waits;
    use_w0 = w0;
    do_xfer(wr, a, d, rd, er, waits);
    chk({name, " prdata"}, 32'(rd), 32'(exp_rd));
    chk({name, " pslverr"}, 32'(er), 32'(exp_err));
    chk({name, " waits"}, 32'(waits), 32'(exp_waits));
    if (wr && !model_err(wr, a)) mem[w0][a] = d;
  endtask

  typedef struct {
    bit         w0;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    bit         exp_err;
    int         exp_waits;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit w0, bit wr, logic [7:0] a, logic [7:0] d,
                              logic [7:0] er, bit ee);
    vec_t v;
    v.w0 = w0; v.wr = wr; v.addr = a; v.wdata = d;
    v.exp_rd = er; v.exp_err = ee; v.exp_waits = w0 ? 0 : 2;
    return v;
  endfunction

  initial begin
    logic [7:0] rd;
    bit er;
    int waits;

    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00; use_w0 = 1'b0;
    model_clear();

    // Stimulus table, WAIT_CYCLES=2 instance first.
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'hA5, 0));
    vecs.push_back(mk(0, 0, 8'h05, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 1, 8'h05, 8'h3C, 8'h00, 0));
    vecs.push_back(mk(0, 0, 8'h05, 8'h00, 8'h3C, 0));
    vecs.push_back(mk(0, 1, 8'h00, 8'hFF, 8'h00, 1));
    vecs.push_back(mk(0, 1, 8'h20, 8'hAA, 8'h00, 1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'hA5, 0));
    vecs.push_back(mk(0, 0, 8'h0F, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 0, 8'h10, 8'h00, 8'h00, 1));
    vecs.push_back(mk(0, 0, 8'h05, 8'h00, 8'h3C, 0));
    vecs.push_back(mk(0, 0, 8'hFF, 8'h00, 8'h00, 1));
    vecs.push_back(mk(0, 1, 8'h0F, 8'h81, 8'h00, 0));
    vecs.push_back(mk(0, 0, 8'h0F, 8'h00, 8'h81, 0));
    // WAIT_CYCLES=0 instance: back-to-back writes then reads of 1..10.
    vecs.push_back(mk(1, 0, 8'h00, 8'h00, 8'hA5, 0));
    vecs.push_back(mk(1, 0, 8'h05, 8'h00, 8'h00, 0));
    for (int i = 1; i <= 10; i++) vecs.push_back(mk(1, 1, 8'(i), 8'(i * 17 + 3), 8'h00, 0));
    for (int i = 1; i <= 10; i++) vecs.push_back(mk(1, 0, 8'(i), 8'h00, 8'(i * 17 + 3), 0));
    vecs.push_back(mk(1, 1, 8'h10, 8'h11, 8'h00, 1));

    // Reset state on both instances.
    #1;
    chk("reset pready2", 32'(pready2), 32'd0);
    chk("reset pslverr2", 32'(pslverr2), 32'd0);
    chk("reset prdata2", 32'(prdata2), 32'd0);
    chk("reset pready0", 32'(pready0), 32'd0);
    chk("reset pslverr0", 32'(pslverr0), 32'd0);
    chk("reset prdata0", 32'(prdata0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_xfer($sformatf("vec%0d", i), vecs[i].w0, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
               vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_waits);
    end

    // PENABLE dropped mid-access: re-setup to a new address, wait count restarts.
    use_w0 = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h0F;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    penable = 1'b0; paddr = 8'h05;
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    while (!pready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    chk("resetup waits", 32'(waits), 32'd2);
    chk("resetup prdata", 32'(prdata), 32'(model_rd(0, 0, 8'h05)));
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;

    // PSEL dropped after one wait cycle of a write: no commit.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h03; pwdata = 8'h77;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("abort pready", 32'(pready), 32'd0);
    run_xfer("abort readback", 0, 0, 8'h03, 8'h00, 8'h00, 0, 2);

    // Reset during the completion cycle of a write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 8'h55;
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    while (!pready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    chk("prereset pready", 32'(pready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset pready", 32'(pready), 32'd0);
    chk("midreset pslverr", 32'(pslverr), 32'd0);
    psel = 1'b0; penable = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_xfer("reset rd4", 0, 0, 8'h04, 8'h00, 8'h00, 0, 2);
    run_xfer("reset rd3", 0, 0, 8'h03, 8'h00, 8'h00, 0, 2);
    run_xfer("reset rd w0 5", 1, 0, 8'h05, 8'h00, 8'h00, 0, 0);

    // Randomized traffic against the memory model.
    for (int i = 0; i < 300; i++) begin
      bit         w0, wr;
      logic [7:0] a, d;
      w0 = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 17));
      d  = 8'($urandom);
      run_xfer($sformatf("rnd%0d", i), w0, wr, a, d, model_rd(w0, wr, a), model_err(wr, a),
               w0 ? 0 : 2);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
